// File: rtl/tpu_seq_pkg.sv
// Shared types and default latencies for the TPU tile sequencer.
package tpu_seq_pkg;

    // Default weight SRAM read latency, in cycles.
    localparam int unsigned DEF_SRAM_RD_LAT = 1;
    // Default cycles from a row's UB read to its result SRAM write.
    localparam int unsigned DEF_RESULT_LAT  = 66;

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StStream,
        StDrain,
        StDone
    } seq_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Host configuration and datapath control bundle of the tile sequencer.
// master: host side (drives start/abort/cfg), slave: the sequencer.
interface tpu_tile_sequencer_if #(
    parameter int unsigned ADDRESSSIZE   = 10,
    parameter int unsigned ADDRESSSIZE_W = 2
) ();

    logic                     start;
    logic                     abort;
    logic [ADDRESSSIZE-1:0]   cfg_ub_base;
    logic [ADDRESSSIZE:0]     cfg_rows;
    logic [ADDRESSSIZE-1:0]   cfg_res_base;
    logic [ADDRESSSIZE_W-1:0] cfg_w_sel;

    logic [ADDRESSSIZE_W-1:0] w_addr;
    logic                     we_rl;
    logic                     ub_rd_en;
    logic [ADDRESSSIZE-1:0]   ub_addr;
    logic                     res_we;
    logic [ADDRESSSIZE-1:0]   res_addr;
    logic                     busy;
    logic                     done;
    logic [15:0]              perf_cycles;

    modport master (
        output start, abort, cfg_ub_base, cfg_rows, cfg_res_base, cfg_w_sel,
        input  w_addr, we_rl, ub_rd_en, ub_addr, res_we, res_addr, busy, done, perf_cycles
    );

    modport slave (
        input  start, abort, cfg_ub_base, cfg_rows, cfg_res_base, cfg_w_sel,
        output w_addr, we_rl, ub_rd_en, ub_addr, res_we, res_addr, busy, done, perf_cycles
    );

endinterface

// File: rtl/seq_result_tracker.sv
// Result-side tracker: armed in the first STREAM cycle, waits RESULT_LAT cycles,
// then issues one result SRAM write per row and flags the final write.
module seq_result_tracker
    import tpu_seq_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned RESULT_LAT  = DEF_RESULT_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   arm,
    input  logic                   clear,
    input  logic [ADDRESSSIZE:0]   rows,
    input  logic [ADDRESSSIZE-1:0] res_base,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   last
);

    localparam int unsigned        LatW    = cnt_width(RESULT_LAT);
    localparam logic [LatW-1:0]    LatLoad = LatW'(RESULT_LAT - 1);
    localparam logic [LatW-1:0]    LatOne  = LatW'(1);
    localparam logic [ADDRESSSIZE:0] CntOne = (ADDRESSSIZE + 1)'(1);

    logic                 pending_q;
    logic [LatW-1:0]      lat_q;
    logic [ADDRESSSIZE:0] wr_cnt_q;

    assign res_we   = pending_q && (lat_q == '0);
    assign res_addr = res_we ? (res_base + wr_cnt_q[ADDRESSSIZE-1:0]) : '0;
    assign last     = res_we && (wr_cnt_q == (rows - CntOne));

    // Latency countdown, then write counter; clear beats arm.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= 1'b0;
            lat_q     <= '0;
            wr_cnt_q  <= '0;
        end else if (clear) begin
            pending_q <= 1'b0;
            lat_q     <= '0;
            wr_cnt_q  <= '0;
        end else if (arm) begin
            pending_q <= 1'b1;
            lat_q     <= LatLoad;
            wr_cnt_q  <= '0;
        end else if (pending_q) begin
            if (lat_q != '0) begin
                lat_q <= lat_q - LatOne;
            end else if (last) begin
                pending_q <= 1'b0;
                wr_cnt_q  <= '0;
            end else begin
                wr_cnt_q <= wr_cnt_q + CntOne;
            end
        end
    end

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Control FSM for one matrix-multiply tile: weight select/reload, UB row
// streaming, and result SRAM write sequencing.
// Optional busy-cycle counter enabled by defining TPU_SEQ_PERF_CNT_EN.
module tpu_tile_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE   = 10,
    parameter int unsigned ADDRESSSIZE_W = 2,
    parameter int unsigned SRAM_RD_LAT   = DEF_SRAM_RD_LAT,
    parameter int unsigned RESULT_LAT    = DEF_RESULT_LAT
) (
    input logic                 clk,
    input logic                 rstn,
    tpu_tile_sequencer_if.slave bus
);

    localparam int unsigned          WcntW    = cnt_width(SRAM_RD_LAT);
    localparam logic [WcntW-1:0]     WcntLast = WcntW'(SRAM_RD_LAT);
    localparam logic [WcntW-1:0]     WcntOne  = WcntW'(1);
    localparam logic [ADDRESSSIZE:0] RowsMax  = {1'b1, {ADDRESSSIZE{1'b0}}};
    localparam logic [ADDRESSSIZE:0] RowOne   = (ADDRESSSIZE + 1)'(1);

    seq_state_e                 state_q, state_d;
    logic [WcntW-1:0]           wcnt_q;
    logic [ADDRESSSIZE:0]       row_q;
    logic [ADDRESSSIZE:0]       rows_q;
    logic [ADDRESSSIZE-1:0]     ub_base_q;
    logic [ADDRESSSIZE-1:0]     res_base_q;
    logic [ADDRESSSIZE_W-1:0]   w_sel_q;

    logic                 start_acc;
    logic                 abort_act;
    logic [ADDRESSSIZE:0] rows_eff;
    logic                 arm;
    logic                 last_wr;

    assign start_acc = (state_q == StIdle) && bus.start;
    assign abort_act = (state_q != StIdle) && bus.abort;
    assign rows_eff  = (bus.cfg_rows > RowsMax) ? RowsMax : bus.cfg_rows;
    assign arm       = (state_q == StStream) && (row_q == '0);

    // Next-state decode; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.start) state_d = (rows_eff == '0) ? StDone : StWload;
            StWload:  if (wcnt_q == WcntLast) state_d = StStream;
            StStream: if (row_q == (rows_q - RowOne)) state_d = StDrain;
            StDrain:  if (last_wr) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort_act) state_d = StIdle;
    end

    // State register, phase counters and configuration latched at start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            row_q      <= '0;
            rows_q     <= '0;
            ub_base_q  <= '0;
            res_base_q <= '0;
            w_sel_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= (state_q == StWload && state_d == StWload) ? wcnt_q + WcntOne : '0;
            row_q   <= (state_q == StStream && state_d == StStream) ? row_q + RowOne : '0;
            if (start_acc) begin
                rows_q     <= rows_eff;
                ub_base_q  <= bus.cfg_ub_base;
                res_base_q <= bus.cfg_res_base;
                w_sel_q    <= bus.cfg_w_sel;
            end
        end
    end

    seq_result_tracker #(
        .ADDRESSSIZE (ADDRESSSIZE),
        .RESULT_LAT  (RESULT_LAT)
    ) u_tracker (
        .clk      (clk),
        .rstn     (rstn),
        .arm      (arm),
        .clear    (abort_act),
        .rows     (rows_q),
        .res_base (res_base_q),
        .res_we   (bus.res_we),
        .res_addr (bus.res_addr),
        .last     (last_wr)
    );

    // A zero-row tile never visits WLOAD, so it never selects a weight set.
    assign bus.w_addr   = (state_q != StIdle && rows_q != '0) ? w_sel_q : '0;
    assign bus.we_rl    = (state_q == StWload) && (wcnt_q == WcntLast);
    assign bus.ub_rd_en = (state_q == StStream);
    assign bus.ub_addr  = bus.ub_rd_en ? (ub_base_q + row_q[ADDRESSSIZE-1:0]) : '0;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);

`ifdef TPU_SEQ_PERF_CNT_EN
    logic [15:0] perf_q;

    // Busy-cycle counter: cleared on start, saturating, frozen in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (state_q != StIdle && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed self-checking bench for tpu_tile_sequencer (default latencies).
module tb_tpu_tile_sequencer;

    localparam int MaxCyc = 1100;

    logic clk;
    logic rstn;

    tpu_tile_sequencer_if #(.ADDRESSSIZE(10), .ADDRESSSIZE_W(2)) bus ();

    tpu_tile_sequencer #(
        .ADDRESSSIZE   (10),
        .ADDRESSSIZE_W (2),
        .SRAM_RD_LAT   (1),
        .RESULT_LAT    (66)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle trace of one tile run, cycle 0 = start cycle.
    logic       rl_a   [0:MaxCyc-1];
    logic       ube_a  [0:MaxCyc-1];
    logic [9:0] uba_a  [0:MaxCyc-1];
    logic       rse_a  [0:MaxCyc-1];
    logic [9:0] rsa_a  [0:MaxCyc-1];
    logic       done_a [0:MaxCyc-1];
    logic       busy_a [0:MaxCyc-1];
    logic [1:0] w_a    [0:MaxCyc-1];

    int n_rl, first_rl, n_ub, first_ub, n_res, first_res, n_done, first_done, n_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one tile: cfg valid in cycle 0 only, scrambled afterwards.
    task automatic run_tile(input logic [10:0] rows, input logic [9:0] ub_base,
                            input logic [9:0] res_base, input logic [1:0] w_sel,
                            input int abort_at, input int pulse_at, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rl_a[c]   = bus.we_rl;
            ube_a[c]  = bus.ub_rd_en;
            uba_a[c]  = bus.ub_addr;
            rse_a[c]  = bus.res_we;
            rsa_a[c]  = bus.res_addr;
            done_a[c] = bus.done;
            busy_a[c] = bus.busy;
            w_a[c]    = bus.w_addr;
            if (c == 0) begin
                bus.cfg_rows     = rows;
                bus.cfg_ub_base  = ub_base;
                bus.cfg_res_base = res_base;
                bus.cfg_w_sel    = w_sel;
            end else begin
                bus.cfg_rows     = 11'($urandom);
                bus.cfg_ub_base  = 10'($urandom);
                bus.cfg_res_base = 10'($urandom);
                bus.cfg_w_sel    = 2'($urandom);
            end
            bus.start = (c == 0) || (c == pulse_at);
            bus.abort = (c == abort_at);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic scan(input int n);
        n_rl = 0; n_ub = 0; n_res = 0; n_done = 0; n_busy = 0;
        first_rl = -1; first_ub = -1; first_res = -1; first_done = -1;
        for (int c = 0; c < n; c++) begin
            if (rl_a[c])   begin n_rl++;   if (first_rl < 0)   first_rl = c;   end
            if (ube_a[c])  begin n_ub++;   if (first_ub < 0)   first_ub = c;   end
            if (rse_a[c])  begin n_res++;  if (first_res < 0)  first_res = c;  end
            if (done_a[c]) begin n_done++; if (first_done < 0) first_done = c; end
            if (busy_a[c]) n_busy++;
        end
    endtask

    // Expected response of the basic tile: rows=4, ub 0x010, res 0x100, w_sel 2.
    task automatic check_basic(input string t);
        scan(80);
        check_eq({t, ".w_addr_c1"}, 32'(w_a[1]), 2);
        check_eq({t, ".n_we_rl"}, n_rl, 1);
        check_eq({t, ".we_rl_cyc"}, first_rl, 2);
        check_eq({t, ".n_ub"}, n_ub, 4);
        check_eq({t, ".ub_first"}, first_ub, 3);
        for (int k = 0; k < 4; k++) check_eq({t, ".ub_addr"}, 32'(uba_a[3+k]), 16 + k);
        check_eq({t, ".ub_addr_idle"}, 32'(uba_a[7]), 0);
        check_eq({t, ".n_res"}, n_res, 4);
        check_eq({t, ".res_first"}, first_res, 69);
        for (int k = 0; k < 4; k++) check_eq({t, ".res_addr"}, 32'(rsa_a[69+k]), 256 + k);
        check_eq({t, ".done_cyc"}, first_done, 73);
        check_eq({t, ".n_done"}, n_done, 1);
        check_eq({t, ".n_busy"}, n_busy, 73);
        check_eq({t, ".busy_c73"}, 32'(busy_a[73]), 1);
        check_eq({t, ".w_addr_c73"}, 32'(w_a[73]), 2);
        check_eq({t, ".w_addr_c74"}, 32'(w_a[74]), 0);
    endtask

    initial begin
        int quiet;
        rstn             = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.cfg_rows     = '0;
        bus.cfg_ub_base  = '0;
        bus.cfg_res_base = '0;
        bus.cfg_w_sel    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst.busy", 32'(bus.busy), 0);
        check_eq("rst.outs", {bus.we_rl, bus.ub_rd_en, bus.res_we, bus.done, bus.w_addr}, 0);
        check_eq("rst.perf", 32'(bus.perf_cycles), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle.busy", 32'(bus.busy), 0);

        // 1: basic tile
        run_tile(11'd4, 10'h010, 10'h100, 2'd2, -1, -1, 80);
        check_basic("t1");
`ifdef TPU_SEQ_PERF_CNT_EN
        check_eq("t1.perf", 32'(bus.perf_cycles), 73);
`else
        check_eq("t1.perf", 32'(bus.perf_cycles), 0);
`endif

        // 2: address wrap-around
        run_tile(11'd4, 10'h3FE, 10'h3FF, 2'd1, -1, -1, 80);
        check_eq("t2.ub0", 32'(uba_a[3]), 32'h3FE);
        check_eq("t2.ub1", 32'(uba_a[4]), 32'h3FF);
        check_eq("t2.ub2", 32'(uba_a[5]), 32'h000);
        check_eq("t2.ub3", 32'(uba_a[6]), 32'h001);
        check_eq("t2.res0", 32'(rsa_a[69]), 32'h3FF);
        check_eq("t2.res1", 32'(rsa_a[70]), 32'h000);
        check_eq("t2.res2", 32'(rsa_a[71]), 32'h001);
        check_eq("t2.res3", 32'(rsa_a[72]), 32'h002);

        // 3: zero rows
        run_tile(11'd0, 10'h010, 10'h100, 2'd3, -1, -1, 10);
        scan(10);
        check_eq("t3.done_cyc", first_done, 1);
        check_eq("t3.n_done", n_done, 1);
        check_eq("t3.n_we_rl", n_rl, 0);
        check_eq("t3.n_ub", n_ub, 0);
        check_eq("t3.n_res", n_res, 0);
        check_eq("t3.n_busy", n_busy, 1);
        check_eq("t3.busy_c1", 32'(busy_a[1]), 1);
`ifdef TPU_SEQ_PERF_CNT_EN
        check_eq("t3.perf", 32'(bus.perf_cycles), 1);
`endif

        // 4: abort mid-drain, then a clean rerun
        run_tile(11'd4, 10'h010, 10'h100, 2'd2, 40, -1, 80);
        scan(80);
        quiet = 0;
        for (int c = 41; c < 80; c++) begin
            if (rl_a[c] || ube_a[c] || rse_a[c] || done_a[c] || busy_a[c] ||
                uba_a[c] != '0 || rsa_a[c] != '0 || w_a[c] != '0) quiet++;
        end
        check_eq("t4.busy_c40", 32'(busy_a[40]), 1);
        check_eq("t4.active_after_abort", quiet, 0);
        check_eq("t4.n_res", n_res, 0);
        check_eq("t4.n_done", n_done, 0);
        run_tile(11'd4, 10'h010, 10'h100, 2'd2, -1, -1, 80);
        check_basic("t4r");

        // 5: start while busy is ignored; start+abort in IDLE starts
        run_tile(11'd4, 10'h010, 10'h100, 2'd2, -1, 10, 80);
        check_basic("t5a");
        run_tile(11'd4, 10'h010, 10'h100, 2'd2, 0, -1, 80);
        check_basic("t5b");

        // 6: oversized row count clamps to 1024
        run_tile(11'd2000, 10'h000, 10'h000, 2'd0, -1, -1, MaxCyc);
        scan(MaxCyc);
        check_eq("t6.n_ub", n_ub, 1024);
        check_eq("t6.n_res", n_res, 1024);
        check_eq("t6.ub_last", 32'(uba_a[1026]), 32'h3FF);
        check_eq("t6.res_first", first_res, 69);
        check_eq("t6.done_cyc", first_done, 1093);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
